// File: rtl/bnn_accum_ctrl.sv
// Neuron pre-activation accumulator for a binary MLP layer.
// Loads a bias, then adds/subtracts N_TERMS signed 15-bit popcount partial sums
// through one shared adder_15b, saturating on two's-complement overflow.

// 15-bit two's-complement adder with signed overflow detection.
module adder_15b (
   input  logic [14:0] a,
   input  logic [14:0] b,
   input  logic        cin,
   output logic [14:0] sum,
   output logic        overflow
);

   // Overflow when both operands share a sign the result does not.
   always_comb begin
      sum      = a + b + {14'd0, cin};
      overflow = (a[14] == b[14]) && (sum[14] != a[14]);
   end

endmodule

module bnn_accum_ctrl #(
   parameter int unsigned N_TERMS = 16,
   parameter int unsigned CNT_W   = $clog2(N_TERMS) + 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [14:0] bias,
   input  logic        clear,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [14:0] in_data,
   input  logic        in_neg,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [14:0] out_sum,
   output logic        out_act,
   output logic        out_sat,
   output logic        busy
);

   localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(N_TERMS - 1);

   typedef enum logic [1:0] {StIdle, StAcc, StDone} state_t;

   state_t             state_q, state_d;
   logic [14:0]        acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               sat_q, sat_d;

   logic [14:0]        adder_b;
   logic               adder_cin;
   logic [14:0]        adder_sum;
   logic               adder_ovf;
   logic [14:0]        sat_result;

   // Subtraction is a + ~d + 1 on the same adder.
   always_comb begin
      adder_b   = in_neg ? ~in_data : in_data;
      adder_cin = in_neg;
   end

   adder_15b u_adder (
      .a        (acc_q),
      .b        (adder_b),
      .cin      (adder_cin),
      .sum      (adder_sum),
      .overflow (adder_ovf)
   );

   // On overflow the true result has the sign of acc, so clamp towards it.
   always_comb begin
      if (adder_ovf) begin
         sat_result = acc_q[14] ? 15'h4000 : 15'h3FFF;
      end else begin
         sat_result = adder_sum;
      end
   end

   // Next-state, datapath update and handshake outputs; clear overrides everything.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      sat_d     = sat_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               acc_d   = bias;
               cnt_d   = '0;
               sat_d   = 1'b0;
               state_d = StAcc;
            end
         end
         StAcc: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid) begin
               acc_d = sat_result;
               cnt_d = cnt_q + CNT_W'(1);
               sat_d = sat_q | adder_ovf;
               if (cnt_q == LAST_TERM) begin
                  state_d = StDone;
               end
            end
         end
         StDone: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) begin
               state_d = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (clear) begin
         state_d = StIdle;
         acc_d   = '0;
         cnt_d   = '0;
         sat_d   = 1'b0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         acc_q   <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
      end
   end

   // Result outputs come straight from registers and stay stable through DONE.
   always_comb begin
      out_sum = acc_q;
      out_act = ~acc_q[14];
      out_sat = sat_q;
   end

endmodule

// File: tb/tb_bnn_accum_ctrl.sv
// Directed bench for bnn_accum_ctrl with N_TERMS=4 and hand-computed results.
module tb_bnn_accum_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [14:0] bias;
   logic        clear;
   logic        in_valid;
   logic        in_ready;
   logic [14:0] in_data;
   logic        in_neg;
   logic        out_valid;
   logic        out_ready;
   logic [14:0] out_sum;
   logic        out_act;
   logic        out_sat;
   logic        busy;

   int total = 0;
   int bad   = 0;

   bnn_accum_ctrl #(.N_TERMS(4)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .bias      (bias),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_neg    (in_neg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_act   (out_act),
      .out_sat   (out_sat),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Source-side protocol: once offered, a term must stay put until accepted.
   logic        prev_valid;
   logic        prev_ready;
   logic [14:0] prev_data;
   always @(posedge clk) begin
      if (rst_n && prev_valid && !prev_ready) begin
         total++;
         assert (in_valid === 1'b1 && in_data === prev_data) else begin
            bad++;
            $error("FAIL src_hold observed=%0b/%0h required=1/%0h", in_valid, in_data, prev_data);
         end
      end
      prev_valid = in_valid;
      prev_ready = in_ready;
      prev_data  = in_data;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
      end
   endtask

   // Offer one term and return just after the edge where it was accepted.
   task automatic send(input logic [14:0] d, input logic neg, output int waited);
      waited   = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_neg   = neg;
      while (!in_ready && waited < 20) begin
         tick();
         waited++;
      end
      check("send_ready", {15'd0, in_ready}, 16'd1);
      tick();
      in_valid = 1'b0;
      in_data  = '0;
      in_neg   = 1'b0;
   endtask

   task automatic do_start(input logic [14:0] b);
      start = 1'b1;
      bias  = b;
      tick();
      start = 1'b0;
      bias  = '0;
   endtask

   task automatic drain();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"}, {15'd0, in_ready}, 16'd0);
      check({tag, "_valid"}, {15'd0, out_valid}, 16'd0);
      check({tag, "_sum"}, {1'b0, out_sum}, 16'd0);
      check({tag, "_act"}, {15'd0, out_act}, 16'd1);
      check({tag, "_sat"}, {15'd0, out_sat}, 16'd0);
      check({tag, "_busy"}, {15'd0, busy}, 16'd0);
   endtask

   initial begin
      int w;
      rst_n = 1'b0; start = 1'b0; bias = '0; clear = 1'b0;
      in_valid = 1'b0; in_data = '0; in_neg = 1'b0; out_ready = 1'b0;
      prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0;
      #12;
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick();
      check_reset_outputs("idle");

      // 1: bias 10, +5 +5 -3 +0 back-to-back -> 17
      do_start(15'd10);
      check("t1_ready", {15'd0, in_ready}, 16'd1);
      check("t1_busy", {15'd0, busy}, 16'd1);
      send(15'd5, 1'b0, w); check("t1_w0", 16'(w), 16'd0);
      send(15'd5, 1'b0, w); check("t1_w1", 16'(w), 16'd0);
      check("t1_mid", {1'b0, out_sum}, 16'd20);
      send(15'd3, 1'b1, w); check("t1_w2", 16'(w), 16'd0);
      send(15'd0, 1'b0, w); check("t1_w3", 16'(w), 16'd0);
      check("t1_valid", {15'd0, out_valid}, 16'd1);
      check("t1_ready_lo", {15'd0, in_ready}, 16'd0);
      check("t1_sum", {1'b0, out_sum}, 16'd17);
      check("t1_act", {15'd0, out_act}, 16'd1);
      check("t1_sat", {15'd0, out_sat}, 16'd0);
      drain();
      check("t1_idle_valid", {15'd0, out_valid}, 16'd0);
      check("t1_idle_busy", {15'd0, busy}, 16'd0);

      // 2: positive saturation, then continue from 16383
      do_start(15'd16380);
      send(15'd10, 1'b0, w);
      check("t2_clamp", {1'b0, out_sum}, 16'h3FFF);
      send(15'd2, 1'b1, w);
      check("t2_after_sub", {1'b0, out_sum}, 16'd16381);
      send(15'd0, 1'b0, w);
      send(15'd0, 1'b0, w);
      check("t2_valid", {15'd0, out_valid}, 16'd1);
      check("t2_sum", {1'b0, out_sum}, 16'd16381);
      check("t2_act", {15'd0, out_act}, 16'd1);
      check("t2_sat", {15'd0, out_sat}, 16'd1);
      drain();

      // 3: -16384 minus 1 clamps at -16384
      do_start(15'h4000);
      send(15'd1, 1'b1, w);
      check("t3_clamp", {1'b0, out_sum}, 16'h4000);
      send(15'd0, 1'b0, w);
      send(15'd0, 1'b0, w);
      send(15'd0, 1'b0, w);
      check("t3_sum", {1'b0, out_sum}, 16'h4000);
      check("t3_act", {15'd0, out_act}, 16'd0);
      check("t3_sat", {15'd0, out_sat}, 16'd1);
      drain();

      // 3b: subtracting -16384 from a non-negative acc clamps to +16383
      do_start(15'd0);
      send(15'h4000, 1'b1, w);
      check("t3b_clamp", {1'b0, out_sum}, 16'h3FFF);
      check("t3b_sat", {15'd0, out_sat}, 16'd1);
      send(15'd0, 1'b0, w);
      send(15'd0, 1'b0, w);
      send(15'd0, 1'b0, w);
      drain();

      // 4: gaps in in_valid, then back-pressure in DONE -> 1+2+3+4 = 10
      do_start(15'd0);
      send(15'd1, 1'b0, w);
      tick(); tick();
      check("t4_gap_sum", {1'b0, out_sum}, 16'd1);
      check("t4_gap_ready", {15'd0, in_ready}, 16'd1);
      send(15'd2, 1'b0, w);
      send(15'd3, 1'b0, w);
      tick(); tick(); tick();
      check("t4_gap2_valid", {15'd0, out_valid}, 16'd0);
      check("t4_gap2_sum", {1'b0, out_sum}, 16'd6);
      send(15'd4, 1'b0, w);
      for (int i = 0; i < 3; i++) begin
         check("t4_hold_valid", {15'd0, out_valid}, 16'd1);
         check("t4_hold_sum", {1'b0, out_sum}, 16'd10);
         tick();
      end
      check("t4_hold_last", {15'd0, out_valid}, 16'd1);
      drain();
      check("t4_released", {15'd0, out_valid}, 16'd0);
      check("t4_released_busy", {15'd0, busy}, 16'd0);

      // 5: clear after two accepts, then async reset mid-ACC
      do_start(15'd7);
      send(15'd1, 1'b0, w);
      send(15'd1, 1'b0, w);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      check_reset_outputs("t5_clr");
      do_start(15'd100);
      send(15'd1, 1'b0, w);
      check("t5_pre_rst", {1'b0, out_sum}, 16'd101);
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("t5_rst");
      rst_n = 1'b1;
      tick();
      do_start(15'd0);
      for (int i = 0; i < 4; i++) send(15'd1, 1'b0, w);
      check("t5_sum", {1'b0, out_sum}, 16'd4);
      check("t5_valid", {15'd0, out_valid}, 16'd1);
      drain();

      // 6: start ignored in ACC and DONE; start at DONE->IDLE edge taken next cycle
      do_start(15'd5);
      send(15'd1, 1'b0, w);
      start = 1'b1; bias = 15'd999;
      tick();
      start = 1'b0; bias = '0;
      check("t6_acc_ignore", {1'b0, out_sum}, 16'd6);
      send(15'd1, 1'b0, w);
      send(15'd1, 1'b0, w);
      send(15'd1, 1'b0, w);
      check("t6_sum", {1'b0, out_sum}, 16'd9);
      start = 1'b1; bias = 15'd50;
      tick();
      check("t6_done_ignore_valid", {15'd0, out_valid}, 16'd1);
      check("t6_done_ignore_sum", {1'b0, out_sum}, 16'd9);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t6_to_idle_busy", {15'd0, busy}, 16'd0);
      check("t6_to_idle_sum", {1'b0, out_sum}, 16'd9);
      tick();
      start = 1'b0; bias = '0;
      check("t6_restart_busy", {15'd0, busy}, 16'd1);
      check("t6_restart_sum", {1'b0, out_sum}, 16'd50);
      for (int i = 0; i < 4; i++) send(15'd0, 1'b0, w);
      check("t6_final_sum", {1'b0, out_sum}, 16'd50);
      check("t6_final_sat", {15'd0, out_sat}, 16'd0);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bnn_accum_ctrl.md
Name: bnn_accum_ctrl

Overview:
- Sequences one shared adder_15b instance to accumulate a neuron pre-activation in a binary MLP layer.
- Loads a bias, then adds or subtracts N_TERMS signed 15-bit partial sums (XNOR-popcount results) delivered over a valid/ready stream.
- Saturates on two's-complement overflow and presents the final sum plus the binary activation on a valid/ready output.
- Sits between the popcount stage and the activation/output buffer.

Parameters:
- N_TERMS, 16, partial sums per neuron; legal range 1..1024.
- CNT_W, $clog2(N_TERMS)+1, term counter width; derived, do not override.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a neuron; sampled only in IDLE.
- bias  in  15  signed bias; sampled with start.
- clear  in  1  synchronous abort to IDLE from any state; priority over all other inputs.
- in_valid  in  1  partial sum available.
- in_ready  out  1  controller accepts a partial sum.
- in_data  in  15  signed partial sum.
- in_neg  in  1  1 = subtract in_data, 0 = add.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  15  signed accumulated sum, saturated.
- out_act  out  1  binary activation: 1 when out_sum >= 0.
- out_sat  out  1  sticky flag: at least one add saturated during this neuron.
- busy  out  1  high in ACC and DONE.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - state=IDLE; acc=0, cnt=0, sat=0.
  - in_ready=0, out_valid=0, out_sum=0, out_act=1, out_sat=0, busy=0.
- States: IDLE, ACC, DONE. Encoding is free.
- IDLE:
  - in_ready=0, out_valid=0.
  - start=1 -> acc<=bias, cnt<=0, sat<=0, state<=ACC.
- ACC:
  - in_ready=1 (combinational from state only).
  - Handshake fires when in_valid & in_ready.
  - On a fire: acc <= sat_result, cnt <= cnt+1, sat <= sat | overflow.
  - If the fire carries term cnt==N_TERMS-1, state <= DONE in the same edge.
  - No fire: acc and cnt hold.
- DONE:
  - out_valid=1, in_ready=0.
  - out_valid & out_ready -> state <= IDLE.
  - acc and sat hold until the next start.
- Adder use: a single adder_15b instance with A=acc.
  - Add: B=in_data, Cin=0.
  - Subtract: B=~in_data, Cin=1.
  - overflow is taken from the instance's overflow output.
- Saturation: if overflow=1, the result is +16383 (0x3FFF) when the true sum is positive, else -16384 (0x4000 as 15-bit, i.e. bit14=1, rest 0).
  - Sign of the true result: A[14] for add; for subtract, the operand signs agree in that case.
  - Equivalent rule: saturate to 0x3FFF when A[14]=0, else 0x4000.
  - Accumulation continues from the saturated value.
- Subtract edge case: subtracting -16384 from acc>=0 overflows and saturates to 0x3FFF. Subtracting it from a negative acc is exact.
- Outputs: out_sum=acc, out_act=~acc[14], out_sat=sat. These are registered, not gated by out_valid, and stable throughout DONE.
- Latency:
  - start to first possible accept: 1 cycle.
  - Last accept to out_valid: 1 cycle.
  - Minimum neuron time: N_TERMS+1 cycles plus the output handshake.
- Simultaneous events:
  - clear=1 overrides start, a fire, and the output handshake: state<=IDLE, acc/cnt/sat<=0.
  - start outside IDLE is ignored.
  - start in the same cycle DONE->IDLE occurs is not seen; start is taken the following cycle.
- Protocol: in_data and in_neg are sampled only on a fire. The source must hold in_valid/in_data stable until in_ready; the bench asserts this.

Test Plan:
1. N_TERMS=4, bias=10, terms +5,+5,-3(in_neg=1 with 3),+0 all back-to-back.
   -> in_ready high 4 cycles; out_valid 1 cycle after the 4th accept; out_sum=17, out_act=1, out_sat=0.
2. bias=16380, terms +10,-2(sub 2),0,0.
   -> first add saturates to 16383, then 16381; out_sum=16381, out_sat=1.
3. bias=-16384, subtract 1, then add 0,0,0.
   -> saturate to -16384; out_sum=-16384, out_act=0, out_sat=1.
4. in_valid gaps: terms delivered on cycles 1,4,5,9, and out_ready held low 3 cycles in DONE.
   -> cnt advances only on fires; out_valid and out_sum held stable until out_ready; state returns to IDLE one cycle after out_ready.
5. clear asserted after 2 accepts; separately, rst_n pulsed low mid-ACC asynchronously.
   -> IDLE next edge (clear) or immediately (reset); all outputs at reset values; next start with bias=0, four +1 terms yields out_sum=4.
6. start asserted during ACC and in DONE with a different bias.
   -> ignored; result unchanged; a subsequent start in IDLE is accepted normally.
